// File: rtl/decrement_then_stop.sv
// -----------------------------------------------------------------------------
// decrement_then_stop
//
// Loadable down-counter with a programmable end value and step. A load sets
// the start count, the stop value and the step. While enabled, the count
// drops by the step each cycle and clamps at the end value. On reaching it,
// the counter stops, pulses done_o for one cycle and waits for the next load.
// Typical use is tracking remaining work in a pipeline tile, such as pixels
// or weights left to process.
//
// A controller can queue a new countdown on the same cycle the current one
// finishes, because ready_o is already high in DONE.
//
// Ports
//   clk_i        in   1     clock; all state changes happen on posedge
//   rst_i        in   1     synchronous, active-high reset (highest priority)
//   load_i       in   1     load request; accepted when load_i & ready_o
//   start_val_i  in   Bits  count value taken on an accepted load
//   end_val_i    in   Bits  stop value, latched on an accepted load
//   step_i       in   Bits  decrement per enabled cycle, latched on load
//                           (a step of 0 is treated as 1)
//   en_i         in   1     decrement enable while running
//   abort_i      in   1     abandon a running countdown without done
//   ready_o      out  1     idle or finished; a load is accepted
//   busy_o       out  1     countdown in progress
//   count_o      out  Bits  current count
//   done_o       out  1     one-cycle pulse on the first cycle count_o == end
// -----------------------------------------------------------------------------
module decrement_then_stop #(
  parameter int Bits = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [Bits-1:0] start_val_i,
  input  logic [Bits-1:0] end_val_i,
  input  logic [Bits-1:0] step_i,
  input  logic            en_i,
  input  logic            abort_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic [Bits-1:0] count_o,
  output logic            done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [Bits-1:0] count_q;
  logic [Bits-1:0] end_q;
  logic [Bits-1:0] step_q;
  logic            done_q;

  // Distance still to travel. While running, count_q > end_q always holds,
  // so this subtraction cannot underflow.
  logic [Bits-1:0] remain;
  logic            last_step;
  logic [Bits-1:0] step_eff;

  assign remain    = count_q - end_q;
  // Compare the remaining distance against the step before subtracting.
  // This lets the final step clamp to end_q instead of wrapping below it.
  assign last_step = (remain <= step_q);
  assign step_eff  = (step_i == '0) ? Bits'(1) : step_i;

  // NOTE: every register in this block is written with non-blocking
  // assignments. All state updates then see pre-edge values, whatever
  // order the statements appear in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      // done_q is a pulse. It is raised only on the edge that lands on
      // end_q, and it clears on the next edge.
      done_q <= 1'b0;

      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (load_i) begin
            end_q  <= end_val_i;
            step_q <= step_eff;
            if (start_val_i > end_val_i) begin
              count_q <= start_val_i;
              state_q <= S_RUN;
            end else begin
              // The start is already at or past the end, so finish at once
              // with no RUN cycle.
              count_q <= end_val_i;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_RUN: begin
          if (abort_i) begin
            state_q <= S_IDLE;
          end else if (en_i) begin
            if (last_step) begin
              count_q <= end_q;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              count_q <= count_q - step_q;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy_o  = (state_q == S_RUN);
  assign count_o = count_q;
  assign done_o  = done_q;

  // Simulation-time sanity checks.
  if (Bits < 1) begin : g_bad_bits
    $error("decrement_then_stop: Bits must be greater than 0");
  end

  a_step_nonzero : assert property (
    @(posedge clk_i) disable iff (rst_i)
      (state_q == S_RUN) |-> (step_q != '0)
  );

endmodule

// File: tb/tb_decrement_then_stop.sv
module tb_decrement_then_stop;

  localparam int Bits = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [Bits-1:0] start_val;
  logic [Bits-1:0] end_val;
  logic [Bits-1:0] step;
  logic            en;
  logic            abort;
  logic            ready;
  logic            busy;
  logic [Bits-1:0] count;
  logic            done;

  int n_checks = 0;
  int n_bad    = 0;

  decrement_then_stop #(.Bits(Bits)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .load_i      (load),
    .start_val_i (start_val),
    .end_val_i   (end_val),
    .step_i      (step),
    .en_i        (en),
    .abort_i     (abort),
    .ready_o     (ready),
    .busy_o      (busy),
    .count_o     (count),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  // Reference model, kept as plain integers. "running" means a countdown
  // is in flight. The next count is max(count - step, end).
  bit m_running;
  int m_count;
  int m_end;
  int m_step;
  bit m_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advances the model using the inputs that will be sampled at the next edge.
  task automatic model_step();
    int nxt;
    if (rst) begin
      m_running = 1'b0;
      m_count   = 0;
      m_end     = 0;
      m_step    = 0;
      m_done    = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_running) begin
        if (load) begin
          m_end  = int'(end_val);
          m_step = (step == 0) ? 1 : int'(step);
          if (int'(start_val) > int'(end_val)) begin
            m_count   = int'(start_val);
            m_running = 1'b1;
          end else begin
            m_count = int'(end_val);
            m_done  = 1'b1;
          end
        end
      end else if (abort) begin
        m_running = 1'b0;
      end else if (en) begin
        nxt = m_count - m_step;
        if (nxt <= m_end) begin
          m_count   = m_end;
          m_done    = 1'b1;
          m_running = 1'b0;
        end else begin
          m_count = nxt;
        end
      end
    end
  endtask

  // One clock: predict, clock, then compare every output 1 ns after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(m_count));
    check("done",  32'(done),  32'(m_done));
    check("ready", 32'(ready), 32'(!m_running));
    check("busy",  32'(busy),  32'(m_running));
  endtask

  task automatic idle_inputs();
    rst = 0; load = 0; en = 0; abort = 0;
    start_val = '0; end_val = '0; step = '0;
  endtask

  task automatic do_load(input int s, input int e, input int st);
    load = 1; start_val = Bits'(s); end_val = Bits'(e); step = Bits'(st);
    tick();
    load = 0;
  endtask

  int pulses;

  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    check("reset_count", 32'(count), 32'h0);
    check("reset_ready", 32'(ready), 32'h1);
    check("reset_busy",  32'(busy),  32'h0);
    check("reset_done",  32'(done),  32'h0);
    rst = 0;

    // 1: 10 -> 5 by 1.
    en = 1;
    do_load(10, 5, 1);
    check("t1_loaded", 32'(count), 32'd10);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) pulses++;
    end
    check("t1_end_count", 32'(count), 32'd5);
    check("t1_done_at_end", 32'(done), 32'h1);
    tick();
    check("t1_hold", 32'(count), 32'd5);
    check("t1_one_pulse", 32'(pulses), 32'd1);

    // 2: 20 -> 12 by 3, with the last step clamped.
    do_load(20, 12, 3);
    for (int i = 0; i < 3; i++) tick();
    check("t2_clamped", 32'(count), 32'd12);
    check("t2_done", 32'(done), 32'h1);
    tick();

    // 3: a start below the end finishes on the load edge.
    do_load(5, 8, 1);
    check("t3_count", 32'(count), 32'd8);
    check("t3_done", 32'(done), 32'h1);
    check("t3_ready", 32'(ready), 32'h1);
    check("t3_busy", 32'(busy), 32'h0);
    tick();

    // 4: toggling enable with step 0 (treated as 1).
    en = 0;
    do_load(50, 40, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      en = (i % 2 == 0);
      tick();
      if (done) pulses++;
    end
    check("t4_end", 32'(count), 32'd40);
    check("t4_one_pulse", 32'(pulses), 32'd1);

    // 5: a load while running is ignored, abort holds the count, reset clears.
    en = 1;
    do_load(100, 0, 1);
    tick(); tick();
    en = 0; load = 1; start_val = 8'd7; end_val = 8'd3; step = 8'd1;
    tick();
    load = 0;
    check("t5_load_ignored", 32'(count), 32'd98);
    en = 1; abort = 1;
    tick();
    abort = 0;
    check("t5_abort_count", 32'(count), 32'd98);
    check("t5_abort_ready", 32'(ready), 32'h1);
    check("t5_abort_nodone", 32'(done), 32'h0);
    do_load(60, 10, 2);
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("t5_rst_count", 32'(count), 32'h0);
    check("t5_rst_ready", 32'(ready), 32'h1);

    // 6: full range in one step, then a back-to-back load during the done pulse.
    en = 1;
    do_load(255, 0, 255);
    check("t6_loaded", 32'(count), 32'hFF);
    tick();
    check("t6_zero", 32'(count), 32'h0);
    check("t6_done", 32'(done), 32'h1);
    do_load(30, 10, 2);
    check("t6_b2b_count", 32'(count), 32'd30);
    check("t6_b2b_done", 32'(done), 32'h0);
    check("t6_b2b_busy", 32'(busy), 32'h1);

    // Random traffic checked against the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      load      = ($urandom_range(0, 3) == 0);
      start_val = Bits'($urandom);
      end_val   = Bits'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 40));
      step      = Bits'($urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 4));
      en        = ($urandom_range(0, 9) < 7);
      abort     = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
